// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: one-cycle grant per transaction, ownership held
// until a completion pulse or a BUSY timeout releases the bus.
module bus_arbiter #(
  parameter int N_PE    = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64,
  parameter int TMR_W   = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_PE-1:0] req,
  output logic [N_PE-1:0] grant,
  input  logic            mem_ack,
  input  logic            data_ready,
  input  logic            wr_done,
  output logic [ID_W-1:0] owner,
  output logic            owner_valid,
  output logic            timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } state_t;

  localparam bit              TMR_EN   = (TIMEOUT > 0);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [ID_W-1:0]  LAST_PE  = ID_W'(N_PE - 1);

  state_t            state, state_nxt;
  logic [ID_W-1:0]   ptr, ptr_nxt;
  logic [TMR_W-1:0]  timer, timer_nxt;
  logic [N_PE-1:0]   grant_nxt;
  logic [ID_W-1:0]   owner_nxt;
  logic              owner_valid_nxt;
  logic              timeout_err_nxt;
  logic              done;
  logic [ID_W-1:0]   winner;

  // First requester found scanning upward from p, wrapping at N_PE.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_PE-1:0] r,
                                               input logic [ID_W-1:0] p);
    logic [ID_W-1:0] sel;
    logic            found;
    logic [N_PE-1:0] probe;
    int              idx;
    sel   = p;
    found = 1'b0;
    for (int k = 0; k < N_PE; k++) begin
      idx = int'(p) + k;
      if (idx >= N_PE) idx = idx - N_PE;
      probe = N_PE'(1) << idx;
      if (!found && (|(r & probe))) begin
        found = 1'b1;
        sel   = ID_W'(idx);
      end
    end
    return sel;
  endfunction

  function automatic logic [ID_W-1:0] after(input logic [ID_W-1:0] o);
    return (o == LAST_PE) ? '0 : o + ID_W'(1);
  endfunction

  assign done   = mem_ack | data_ready | wr_done;
  assign winner = rr_pick(req, ptr);

  always_comb begin
    state_nxt       = state;
    ptr_nxt         = ptr;
    timer_nxt       = timer;
    grant_nxt       = '0;
    owner_nxt       = owner;
    owner_valid_nxt = owner_valid;
    timeout_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt       = GRANT;
          grant_nxt       = N_PE'(1) << winner;
          owner_nxt       = winner;
          owner_valid_nxt = 1'b1;
        end
      end
      GRANT: begin
        if (done) begin
          state_nxt       = IDLE;
          owner_valid_nxt = 1'b0;
          ptr_nxt         = after(owner);
        end else begin
          state_nxt = BUSY;
          timer_nxt = '0;
        end
      end
      BUSY: begin
        // A completion on the timeout edge is a normal release.
        if (done) begin
          state_nxt       = IDLE;
          owner_valid_nxt = 1'b0;
          ptr_nxt         = after(owner);
        end else if (TMR_EN && (timer == TMR_LAST)) begin
          state_nxt       = IDLE;
          owner_valid_nxt = 1'b0;
          ptr_nxt         = after(owner);
          timeout_err_nxt = 1'b1;
        end else if (TMR_EN) begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      default: begin
        state_nxt       = IDLE;
        owner_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      timer       <= '0;
      grant       <= '0;
      owner       <= '0;
      owner_valid <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      timer       <= timer_nxt;
      grant       <= grant_nxt;
      owner       <= owner_nxt;
      owner_valid <= owner_valid_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
  a_grant_owned:  assert property (@(posedge clk) disable iff (reset) (|grant) |-> owner_valid);
  a_grant_pulse:  assert property (@(posedge clk) disable iff (reset) (|grant) |=> !(|grant));

endmodule
